// File: rtl/hack_pkg.sv
// Shared state encoding and Hack instruction field positions for the control FSM.
package hack_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_WAIT_I = 4'd1,
    S_DECODE = 4'd2,
    S_RD_MEM = 4'd3,
    S_WAIT_R = 4'd4,
    S_WR_MEM = 4'd5,
    S_WAIT_W = 4'd6,
    S_WB     = 4'd7,
    S_HALTED = 4'd8,
    S_ERROR  = 4'd9
  } state_e;

  localparam int unsigned C_FLAG = 15;
  localparam int unsigned A_BIT  = 12;
  localparam int unsigned ZA_BIT = 11;
  localparam int unsigned NA_BIT = 10;
  localparam int unsigned ZB_BIT = 9;
  localparam int unsigned NB_BIT = 8;
  localparam int unsigned F_BIT  = 7;
  localparam int unsigned NO_BIT = 6;
  localparam int unsigned DEST_A = 5;
  localparam int unsigned DEST_D = 4;
  localparam int unsigned DEST_M = 3;
  localparam int unsigned J_LT   = 2;
  localparam int unsigned J_EQ   = 1;
  localparam int unsigned J_GT   = 0;

endpackage

// File: rtl/hack_jump_unit.sv
// Combinational PC-load decision from the jump field and the ALU flags.
module hack_jump_unit
  import hack_pkg::*;
(
  input  logic       c_i,
  input  logic [2:0] jmp_i,
  input  logic       zr_i,
  input  logic       zn_i,
  output logic       load_o
);

  always_comb begin
    load_o = c_i & ((zn_i & jmp_i[J_LT]) |
                    (zr_i & jmp_i[J_EQ]) |
                    (jmp_i[J_GT] & ~zn_i & ~zr_i));
  end

endmodule

// File: rtl/hack_ctrl_fsm.sv
// Hack CPU control FSM: SPI fetch/operand handshakes, IR decode, halt/step
// control and a per-access SPI timeout with sticky error.
module hack_ctrl_fsm
  import hack_pkg::*;
#(
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] spiData_i,
  input  logic               spiDone_i,
  input  logic               halt_i,
  input  logic               stepMode_i,
  input  logic               step_i,
  input  logic               zr_i,
  input  logic               zn_i,
  output logic               spiStart_o,
  output logic               rwb_o,
  output logic               selSPIAddress_o,
  output logic               selSPIDest_o,
  output logic               enA_o,
  output logic               enD_o,
  output logic               enPC_o,
  output logic               loadPC_o,
  output logic               selA_o,
  output logic               selALU_o,
  output logic               za_o,
  output logic               na_o,
  output logic               zb_o,
  output logic               nb_o,
  output logic               f_o,
  output logic               no_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               halted_o,
  output logic               error_o,
  output logic [3:0]         state_o
);

  localparam int unsigned          CB   = INSTR_W - 1;
  localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [TIMEOUT_W-1:0] wcnt_q, wcnt_d;
  logic                 bypass_q, bypass_d;
  logic                 jump;
  logic                 fetch_go;

  hack_jump_unit u_jump (
    .c_i    (ir_q[CB]),
    .jmp_i  (ir_q[J_LT:J_GT]),
    .zr_i   (zr_i),
    .zn_i   (zn_i),
    .load_o (jump)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      wcnt_q   <= '0;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      wcnt_q   <= wcnt_d;
      bypass_q <= bypass_d;
    end
  end

  // A step release lets exactly one fetch ignore halt_i; reset masks the
  // FETCH start so every control output is quiet while reset is held.
  assign fetch_go = ~reset & (~halt_i | bypass_q);

  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    wcnt_d          = '0;
    bypass_d        = bypass_q;
    spiStart_o      = 1'b0;
    rwb_o           = 1'b0;
    selSPIAddress_o = 1'b0;
    selSPIDest_o    = 1'b0;
    enA_o           = 1'b0;
    enD_o           = 1'b0;
    enPC_o          = 1'b0;
    loadPC_o        = 1'b0;
    halted_o        = 1'b0;
    error_o         = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (fetch_go) begin
          spiStart_o = 1'b1;
          rwb_o      = 1'b1;
          bypass_d   = 1'b0;
          state_d    = S_WAIT_I;
        end else begin
          state_d = S_HALTED;
        end
      end
      S_WAIT_I: begin
        rwb_o = 1'b1;
        if (spiDone_i) begin
          ir_d    = spiData_i;
          state_d = S_DECODE;
        end else if (wcnt_q == TMAX) begin
          state_d = S_ERROR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (ir_q[CB] & ir_q[A_BIT])       state_d = S_RD_MEM;
        else if (ir_q[CB] & ir_q[DEST_M]) state_d = S_WR_MEM;
        else                              state_d = S_WB;
      end
      S_RD_MEM: begin
        spiStart_o      = 1'b1;
        rwb_o           = 1'b1;
        selSPIAddress_o = 1'b1;
        selSPIDest_o    = 1'b1;
        state_d         = S_WAIT_R;
      end
      S_WAIT_R: begin
        rwb_o           = 1'b1;
        selSPIAddress_o = 1'b1;
        selSPIDest_o    = 1'b1;
        if (spiDone_i) begin
          state_d = ir_q[DEST_M] ? S_WR_MEM : S_WB;
        end else if (wcnt_q == TMAX) begin
          state_d = S_ERROR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WR_MEM: begin
        spiStart_o      = 1'b1;
        selSPIAddress_o = 1'b1;
        state_d         = S_WAIT_W;
      end
      S_WAIT_W: begin
        selSPIAddress_o = 1'b1;
        if (spiDone_i) begin
          state_d = S_WB;
        end else if (wcnt_q == TMAX) begin
          state_d = S_ERROR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WB: begin
        enPC_o   = 1'b1;
        enA_o    = ~ir_q[CB] | ir_q[DEST_A];
        enD_o    = ir_q[CB] & ir_q[DEST_D];
        loadPC_o = jump;
        state_d  = stepMode_i ? S_HALTED : S_FETCH;
      end
      S_HALTED: begin
        halted_o = 1'b1;
        if (step_i) begin
          bypass_d = 1'b1;
          state_d  = S_FETCH;
        end else if (~halt_i & ~stepMode_i) begin
          state_d = S_FETCH;
        end
      end
      S_ERROR: begin
        error_o = 1'b1;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  assign selA_o   = ~ir_q[CB];
  assign selALU_o = ir_q[A_BIT];
  assign za_o     = ir_q[ZA_BIT];
  assign na_o     = ir_q[NA_BIT];
  assign zb_o     = ir_q[ZB_BIT];
  assign nb_o     = ir_q[NB_BIT];
  assign f_o      = ir_q[F_BIT];
  assign no_o     = ir_q[NO_BIT];
  assign instr_o  = ir_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_hack_ctrl_fsm.sv
// Bench for hack_ctrl_fsm: instruction-plan reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_hack_ctrl_fsm;

  localparam int TOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] spiData_i;
  logic        spiDone_i, halt_i, stepMode_i, step_i, zr_i, zn_i;
  logic        spiStart_o, rwb_o, selSPIAddress_o, selSPIDest_o;
  logic        enA_o, enD_o, enPC_o, loadPC_o;
  logic        selA_o, selALU_o, za_o, na_o, zb_o, nb_o, f_o, no_o;
  logic [15:0] instr_o;
  logic        halted_o, error_o;
  logic [3:0]  state_o;

  always #5 clk = ~clk;

  hack_ctrl_fsm #(.INSTR_W(16), .TIMEOUT_W(8), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .spiData_i(spiData_i), .spiDone_i(spiDone_i),
    .halt_i(halt_i), .stepMode_i(stepMode_i), .step_i(step_i),
    .zr_i(zr_i), .zn_i(zn_i), .spiStart_o(spiStart_o), .rwb_o(rwb_o),
    .selSPIAddress_o(selSPIAddress_o), .selSPIDest_o(selSPIDest_o),
    .enA_o(enA_o), .enD_o(enD_o), .enPC_o(enPC_o), .loadPC_o(loadPC_o),
    .selA_o(selA_o), .selALU_o(selALU_o), .za_o(za_o), .na_o(na_o),
    .zb_o(zb_o), .nb_o(nb_o), .f_o(f_o), .no_o(no_o), .instr_o(instr_o),
    .halted_o(halted_o), .error_o(error_o), .state_o(state_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: current phase plus the remaining phases of the
  // instruction, planned in one go once the instruction word is known.
  int          cur;
  int          plan[$];
  logic [15:0] m_ir;
  bit          m_bypass;
  int          m_idle;
  int          resp_d;
  bit          rnd_mode = 1'b0;

  int starts_rwb[$];
  int wb_seen;
  bit wb_enA, wb_enD, wb_enPC, wb_load;
  bit rd_rwb, rd_addr, rd_dest;

  function automatic bit is_wait(int s);
    return (s == 1) || (s == 4) || (s == 6);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkN(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur = 0;
    plan.delete();
    m_ir = '0;
    m_bypass = 1'b0;
    m_idle = 0;
  endtask

  task automatic compare();
    bit go, c, j;
    go = !reset && (!halt_i || m_bypass);
    c  = m_ir[15];
    j  = c && ((zn_i && m_ir[2]) || (zr_i && m_ir[1]) || (m_ir[0] && !zn_i && !zr_i));
    chkN("state", 32'(state_o), cur);
    chk1("spiStart", spiStart_o, (cur == 0 && go) || cur == 3 || cur == 5);
    chk1("rwb", rwb_o, (cur == 0 && go) || cur == 1 || cur == 3 || cur == 4);
    chk1("selSPIAddress", selSPIAddress_o, cur >= 3 && cur <= 6);
    chk1("selSPIDest", selSPIDest_o, cur == 3 || cur == 4);
    chk1("enPC", enPC_o, cur == 7);
    chk1("enA", enA_o, cur == 7 && (!c || m_ir[5]));
    chk1("enD", enD_o, cur == 7 && c && m_ir[4]);
    chk1("loadPC", loadPC_o, cur == 7 && j);
    chkN("decode", 32'({selA_o, selALU_o, za_o, na_o, zb_o, nb_o, f_o, no_o}),
         32'({~m_ir[15], m_ir[12:6]}));
    chkN("instr", 32'(instr_o), 32'(m_ir));
    chk1("halted", halted_o, cur == 8);
    chk1("error", error_o, cur == 9);
    if (spiStart_o === 1'b1) starts_rwb.push_back(int'(rwb_o));
    if (state_o == 4'd7) begin
      wb_seen++;
      wb_enA = enA_o; wb_enD = enD_o; wb_enPC = enPC_o; wb_load = loadPC_o;
    end
    if (state_o == 4'd3) begin
      rd_rwb = rwb_o; rd_addr = selSPIAddress_o; rd_dest = selSPIDest_o;
    end
  endtask

  task automatic model_step();
    if (reset) return;
    case (cur)
      0: begin
        if (!halt_i || m_bypass) begin
          cur = 1; m_idle = 0; m_bypass = 1'b0;
        end else begin
          cur = 8;
        end
      end
      1, 4, 6: begin
        if (spiDone_i) begin
          if (cur == 1) begin
            m_ir = spiData_i;
            plan.delete();
            plan.push_back(2);
            if (spiData_i[15] && spiData_i[12]) begin plan.push_back(3); plan.push_back(4); end
            if (spiData_i[15] && spiData_i[3])  begin plan.push_back(5); plan.push_back(6); end
            plan.push_back(7);
          end
          cur = plan.pop_front();
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == TOUT) cur = 9;
        end
      end
      7: cur = stepMode_i ? 8 : 0;
      8: begin
        if (step_i) begin
          cur = 0; m_bypass = 1'b1;
        end else if (!halt_i && !stepMode_i) begin
          cur = 0;
        end
      end
      9: ;
      default: begin
        cur = plan.pop_front();
        m_idle = 0;
      end
    endcase
  endtask

  // Inputs are already set at the falling edge; settle, compare, advance.
  task automatic tick();
    if (reset) model_reset();
    if (is_wait(cur)) spiDone_i = (resp_d != 0) && (m_idle + 1 == resp_d);
    else              spiDone_i = rnd_mode && ($urandom_range(0, 3) == 0);
    #1;
    compare();
    model_step();
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [15:0] ir, input int n, input logic z,
                           input logic ng, input bit halt_r, output int cyc);
    starts_rwb.delete();
    wb_seen = 0;
    spiData_i = ir; zr_i = z; zn_i = ng; resp_d = n; cyc = 0;
    do begin
      if (halt_r && cur == 4) halt_i = 1'b1;
      tick();
      cyc++;
    end while (!(cur == 0 || cur == 8 || cur == 9) && cyc < 60);
    chk1("instr_bound", cyc < 60, 1'b1);
  endtask

  logic [15:0] tbl [6];
  int cyc;

  initial begin
    tbl[0] = 16'h0005; tbl[1] = 16'hFC10; tbl[2] = 16'hFE18;
    tbl[3] = 16'hEA87; tbl[4] = 16'hE302; tbl[5] = 16'hE308;
    reset = 1'b1; spiData_i = '0; spiDone_i = 1'b0; halt_i = 1'b0;
    stepMode_i = 1'b0; step_i = 1'b0; zr_i = 1'b0; zn_i = 1'b0; resp_d = 0;
    model_reset();
    @(negedge clk);
    tick();
    #1;
    chkN("rst_state", 32'(state_o), 0);
    chk1("rst_selA", selA_o, 1'b1);
    chk1("rst_spiStart", spiStart_o, 1'b0);
    chk1("rst_rwb", rwb_o, 1'b0);
    chk1("rst_error", error_o, 1'b0);
    chkN("rst_instr", 32'(instr_o), 0);
    @(negedge clk);
    reset = 1'b0;

    run_instr(16'h0005, 2, 1'b0, 1'b0, 1'b0, cyc);
    chkN("a_cycles", cyc, 5);
    chk1("a_enA", wb_enA, 1'b1);
    chk1("a_enPC", wb_enPC, 1'b1);
    chk1("a_enD", wb_enD, 1'b0);
    chk1("a_load", wb_load, 1'b0);

    run_instr(16'hFC10, 2, 1'b0, 1'b0, 1'b0, cyc);
    chk1("rd_rwb", rd_rwb, 1'b1);
    chk1("rd_addr", rd_addr, 1'b1);
    chk1("rd_dest", rd_dest, 1'b1);
    chk1("dm_enD", wb_enD, 1'b1);
    chk1("dm_enA", wb_enA, 1'b0);

    run_instr(16'hFE18, 3, 1'b0, 1'b0, 1'b0, cyc);
    chkN("rmw_starts", starts_rwb.size(), 3);
    if (starts_rwb.size() == 3) begin
      chkN("rmw_rwb1", starts_rwb[0], 1);
      chkN("rmw_rwb2", starts_rwb[1], 1);
      chkN("rmw_rwb3", starts_rwb[2], 0);
    end
    chk1("rmw_enD", wb_enD, 1'b1);

    run_instr(16'hEA87, 1, 1'b0, 1'b0, 1'b0, cyc);
    chk1("jmp_load", wb_load, 1'b1);
    run_instr(16'hE302, 1, 1'b0, 1'b0, 1'b0, cyc);
    chk1("jeq_nz_load", wb_load, 1'b0);
    run_instr(16'hE302, 1, 1'b1, 1'b0, 1'b0, cyc);
    chk1("jeq_z_load", wb_load, 1'b1);

    // Done on the last permitted wait cycle must beat the timeout.
    run_instr(16'h0005, TOUT, 1'b0, 1'b0, 1'b0, cyc);
    chkN("edge_cycles", cyc, 7);
    chk1("edge_noerr", error_o, 1'b0);

    stepMode_i = 1'b1;
    run_instr(16'h0005, 1, 1'b0, 1'b0, 1'b0, cyc);
    chkN("step_model_state", cur, 8);
    halt_i = 1'b1;
    wb_seen = 0;
    for (int k = 0; k < 30; k++) begin
      step_i = (k == 3) || (k == 15);
      tick();
    end
    step_i = 1'b0;
    chkN("step_wb_count", wb_seen, 2);
    #1;
    chk1("step_halted", halted_o, 1'b1);
    @(negedge clk);
    stepMode_i = 1'b0; halt_i = 1'b0;
    tick();

    run_instr(16'hFC10, 2, 1'b0, 1'b0, 1'b1, cyc);
    chkN("haltwr_wb", wb_seen, 1);
    tick();
    #1;
    chkN("haltwr_state", 32'(state_o), 8);
    @(negedge clk);
    halt_i = 1'b0;
    tick();

    resp_d = 0; spiData_i = 16'hFFFF;
    for (int k = 0; k < 5; k++) tick();
    #1;
    chk1("to_error", error_o, 1'b1);
    chkN("to_state", 32'(state_o), 9);
    @(negedge clk);
    starts_rwb.delete();
    for (int k = 0; k < 6; k++) tick();
    chkN("to_nostart", starts_rwb.size(), 0);
    reset = 1'b1;
    tick();
    #1;
    chkN("to_rst_state", 32'(state_o), 0);
    chk1("to_rst_error", error_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    rnd_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      reset = ((cur == 9) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 499) == 0);
      halt_i = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) stepMode_i = ~stepMode_i;
      step_i = ((cur == 8) && ($urandom_range(0, 5) == 0)) || ($urandom_range(0, 29) == 0);
      zr_i = 1'($urandom_range(0, 1));
      zn_i = 1'($urandom_range(0, 1));
      spiData_i = ($urandom_range(0, 1) == 1) ? tbl[$urandom_range(0, 5)] : 16'($urandom);
      if (cur == 0 || cur == 3 || cur == 5)
        resp_d = ($urandom_range(0, 29) == 0) ? 0 : int'($urandom_range(1, TOUT));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
